// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling ratio.
// Also used by the transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam int OVERSAMPLE = 16;
endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle TICKo every TICK_DIV clocks.
// CLRi holds the phase at zero so the first tick lands TICK_DIV clocks after release.
module uart_baud_tick #(
  parameter int TICK_DIV = 27
) (
  input  logic CLKip,
  input  logic RSTi,
  input  logic CLRi,
  output logic TICKo
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge CLKip) begin
    if (RSTi || CLRi)          tick_cnt <= '0;
    else if (tick_cnt == LAST) tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + CW'(1);
  end

  assign TICKo = (tick_cnt == LAST);
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x oversampling, mid-bit sampling.
// Good bytes are pushed to a FIFO with a one-cycle WEo; framing errors and overruns pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                  CLKip,
  input  logic                  RSTi,
  input  logic                  RXi,
  input  logic                  FULLi,
  output logic [DATA_WIDTH-1:0] DATAo,
  output logic                  WEo,
  output logic                  BUSYo,
  output logic                  FRAME_ERRo,
  output logic                  OVERRUNo
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("uart_rx: TICK_DIV must be >= 2");
  end

  rx_state_t             state, state_nx;
  logic                  rx_meta, rx_s;
  logic                  tick;
  logic [SW-1:0]         samp_cnt, samp_nx;
  logic [BW-1:0]         bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx, data_nx;
  logic                  we_nx, ferr_nx, ovr_nx;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLKip (CLKip),
    .RSTi  (RSTi),
    .CLRi  (state == IDLE),
    .TICKo (tick)
  );

  always_ff @(posedge CLKip) begin
    if (RSTi) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      DATAo      <= '0;
      WEo        <= 1'b0;
      FRAME_ERRo <= 1'b0;
      OVERRUNo   <= 1'b0;
    end else begin
      rx_meta    <= RXi;
      rx_s       <= rx_meta;
      state      <= state_nx;
      samp_cnt   <= samp_nx;
      bit_cnt    <= bit_nx;
      shreg      <= shreg_nx;
      DATAo      <= data_nx;
      WEo        <= we_nx;
      FRAME_ERRo <= ferr_nx;
      OVERRUNo   <= ovr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    samp_nx  = samp_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    data_nx  = DATAo;
    we_nx    = 1'b0;
    ferr_nx  = 1'b0;
    ovr_nx   = 1'b0;
    // samp_cnt wraps 15->0 naturally, so bit boundaries need no explicit clear
    if (tick && state != IDLE && state != BREAK) samp_nx = samp_cnt + SW'(1);
    case (state)
      IDLE: begin
        samp_nx = '0;
        bit_nx  = '0;
        if (!rx_s) state_nx = START;
      end
      START: if (tick && samp_cnt == MID) begin
        if (rx_s) state_nx = IDLE;
        else begin
          samp_nx  = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end
      end
      DATA: if (tick && samp_cnt == LAST) begin
        shreg_nx = DATA_WIDTH'({rx_s, shreg} >> 1);
        bit_nx   = bit_cnt + BW'(1);
        if (bit_cnt == LAST_BIT) state_nx = STOP;
      end
      STOP: if (tick && samp_cnt == LAST) begin
        if (rx_s) begin
          // Leave mid stop bit so a back-to-back start edge is not missed
          state_nx = IDLE;
          if (FULLi) ovr_nx = 1'b1;
          else begin
            we_nx   = 1'b1;
            data_nx = shreg;
          end
        end else begin
          ferr_nx  = 1'b1;
          state_nx = BREAK;
        end
      end
      BREAK: if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign BUSYo = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 160 clocks/bit; scoreboard of expected bytes
// compared against bytes captured on WEo, plus a behavioural 16-deep FIFO full flag.
module tb_uart_rx;
  localparam int CF  = 1_600_000;
  localparam int BR  = 10_000;
  localparam int BIT = 160;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, full_force = 1'b0, fifo_mode = 1'b0;
  logic       FULLi;
  logic [7:0] DATAo;
  logic       WEo, BUSYo, FE, OV;

  int tests = 0, fails = 0, cyc = 0, fall_cyc = 0;
  int we_cnt = 0, fe_cnt = 0, ov_cnt = 0, multi_cnt = 0, fifo_cnt = 0, we_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign FULLi = fifo_mode ? (fifo_cnt >= 16) : full_force;

  uart_rx #(.DATA_WIDTH(8), .CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .CLKip(clk), .RSTi(rst), .RXi(rx), .FULLi(FULLi), .DATAo(DATAo),
    .WEo(WEo), .BUSYo(BUSYo), .FRAME_ERRo(FE), .OVERRUNo(OV)
  );

  always @(negedge clk) begin
    if (WEo) begin
      we_cnt++;
      we_cyc = cyc;
      got_q.push_back(DATAo);
      if (fifo_mode) fifo_cnt++;
    end
    if (FE) fe_cnt++;
    if (OV) ov_cnt++;
    if (int'(WEo) + int'(FE) + int'(OV) > 1) multi_cnt++;
    if (!fifo_mode) fifo_cnt = 0;
  end

  // Caller is always at a negedge, so consecutive frames have no gap.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0; fall_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_sb(input string name);
    logic [7:0] g, e;
    while (got_q.size() > 0) begin
      tests++;
      g = got_q.pop_front();
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s: unexpected byte got=%h required=none", name, g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL %s: byte got=%h required=%h", name, g, e);
        end
      end
    end
    while (exp_q.size() > 0) begin
      tests++; fails++;
      e = exp_q.pop_front();
      $display("FAIL %s: missing byte got=none required=%h", name, e);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if ({DATAo, WEo, BUSYo, FE, OV} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got=%h required=000", {DATAo, WEo, BUSYo, FE, OV});
    end
    rst = 1'b0;
    idle(10);
    check_cnt("reset_busy_after", int'(BUSYo), 0);
  endtask

  task automatic test_single();
    int w0 = we_cnt, f0 = fe_cnt, o0 = ov_cnt, fc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    fc = fall_cyc;
    idle(20);
    check_cnt("single_we", we_cnt - w0, 1);
    check_cnt("single_err", (fe_cnt - f0) + (ov_cnt - o0), 0);
    tests++;
    if ((we_cyc - fc) < 1523 || (we_cyc - fc) > 1525) begin
      fails++;
      $display("FAIL single_latency: got=%0d required=1524+-1", we_cyc - fc);
    end
    check_cnt("single_busy_after", int'(BUSYo), 0);
    check_sb("single_data");
  endtask

  task automatic test_back_to_back();
    int w0 = we_cnt, f0 = fe_cnt, o0 = ov_cnt;
    logic [7:0] pat [3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C;
    for (int i = 0; i < 3; i++) exp_q.push_back(pat[i]);
    for (int i = 0; i < 3; i++) send_frame(pat[i], 1'b1);
    idle(20);
    check_cnt("b2b_we", we_cnt - w0, 3);
    check_cnt("b2b_err", (fe_cnt - f0) + (ov_cnt - o0), 0);
    check_sb("b2b_data");
  endtask

  task automatic test_false_start();
    int w0 = we_cnt, f0 = fe_cnt, o0 = ov_cnt;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check_cnt("false_busy_high", int'(BUSYo), 1);
    repeat (30) @(negedge clk);
    idle(150);
    check_cnt("false_busy_low", int'(BUSYo), 0);
    check_cnt("false_strobes", (we_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0), 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(20);
    check_sb("false_follow");
  endtask

  task automatic test_break();
    int w0 = we_cnt, f0 = fe_cnt;
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    repeat (2000) @(negedge clk);
    check_cnt("break_busy", int'(BUSYo), 1);
    check_cnt("break_fe", fe_cnt - f0, 1);
    check_cnt("break_we", we_cnt - w0, 0);
    idle(50);
    check_cnt("break_idle", int'(BUSYo), 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    idle(20);
    check_sb("break_follow");
  endtask

  task automatic test_overrun_reset();
    int w0 = we_cnt, f0 = fe_cnt, o0 = ov_cnt;
    full_force = 1'b1;
    send_frame(8'h77, 1'b1);
    idle(20);
    full_force = 1'b0;
    check_cnt("ovr_pulse", ov_cnt - o0, 1);
    check_cnt("ovr_we", we_cnt - w0, 0);
    check_cnt("ovr_data_kept", int'(DATAo), 8'h12);
    // 0x99 with reset applied and released during the high last data bit
    w0 = we_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rx = (8'h99 >> i) & 1;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (80) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(75 + BIT);
    check_cnt("rst_mid_strobes", (we_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0), 0);
    check_cnt("rst_mid_data", int'(DATAo), 0);
    check_cnt("rst_mid_busy", int'(BUSYo), 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(20);
    check_sb("rst_follow");
  endtask

  task automatic test_fifo();
    int w0 = we_cnt, o0 = ov_cnt;
    fifo_mode = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
    idle(20);
    check_cnt("fifo_writes", we_cnt - w0, 16);
    check_cnt("fifo_overrun", ov_cnt - o0, 1);
    check_sb("fifo_data");
    fifo_mode = 1'b0;
    idle(5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_break();
    test_overrun_reset();
    test_fifo();
    check_cnt("strobes_exclusive", multi_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames that feeds the receive FIFO. It synchronises the asynchronous `RXi` line and oversamples it 16×, validates the start bit, then assembles LSB-first data bits and checks the stop bit. Each good byte is pushed with a single-cycle write strobe that connects directly to the FIFO's `WEi`/`DATAi`/`FULLo` ports. Framing errors and overruns (byte completed while the FIFO is full) are reported as pulses.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `CLK_FREQ`, 50_000_000: `CLKip` frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in baud.
- Derived localparam `TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)`, integer division (27 at defaults). `TICK_DIV ≥ 2` is required; elaboration fails otherwise.

- `CLKip` input 1: system clock.
- `RSTi` input 1: **synchronous, active-high reset**.
- `RXi` input 1: serial line, asynchronous, idle high.
- `FULLi` input 1: FIFO full flag (FIFO `FULLo`).
- `DATAo` output DATA_WIDTH: last received byte, to FIFO `DATAi`.
- `WEo` output 1: one-cycle push strobe, to FIFO `WEi`.
- `BUSYo` output 1: high whenever state ≠ IDLE.
- `FRAME_ERRo` output 1: one-cycle pulse, stop bit sampled low.
- `OVERRUNo` output 1: one-cycle pulse, good byte dropped because `FULLi` was high.

## Operation
- **Synchroniser:** 2-FF on `RXi`; both flops reset to 1. All decisions use the synchronised bit `rx_s`.
- **Tick generator:** counter 0..TICK_DIV-1 emits `tick` when it equals TICK_DIV-1. It is held at 0 in IDLE and restarts from 0 on start detection, so sample phase aligns to the start edge.
- `OVERSAMPLE = 16`.
- **States:**
  - **IDLE:** `rx_s == 0` → go to START; clear `tick_cnt` and `samp_cnt`.
  - **START:** count ticks. On the tick where `samp_cnt == 7` (mid start bit):
    - `rx_s == 1` → false start, return to IDLE with no pulse.
    - `rx_s == 0` → clear `samp_cnt`, clear `bit_cnt`, go to DATA.
  - **DATA:** on the tick where `samp_cnt == 15`, shift `rx_s` into the MSB of the shift register (shift right, so LSB arrives first) and increment `bit_cnt`. After DATA_WIDTH bits, go to STOP.
  - **STOP:** on the tick where `samp_cnt == 15`, sample `rx_s`:
    - `rx_s == 1` and `!FULLi` → `DATAo ← shreg`, `WEo` pulse.
    - `rx_s == 1` and `FULLi` → `OVERRUNo` pulse; `DATAo` unchanged.
    - `rx_s == 0` → `FRAME_ERRo` pulse, no write; go to BREAK.
    - For either `rx_s == 1` case, go to IDLE immediately (mid stop bit), which permits back-to-back frames.
  - **BREAK:** wait for `rx_s == 1`, then go to IDLE. A held-low line produces exactly one `FRAME_ERRo`.
- `FULLi` is sampled only on the stop-bit decision cycle.
- At most one of `WEo`, `FRAME_ERRo`, `OVERRUNo` is high in any cycle.
- `DATAo` is registered and changes only together with `WEo`.
- **Reset values:** state IDLE, `DATAo = 0`, `WEo = FRAME_ERRo = OVERRUNo = BUSYo = 0`, synchroniser = 1, all counters 0.
- **Reset mid-frame:** the frame is abandoned with no strobe. The line must go high, then low again, before reception resumes, because synchroniser = 1 forces IDLE.

## Timing
- Start detection: 3 `CLKip` cycles after the `RXi` falling edge (2 synchroniser cycles + 1 IDLE→START cycle).
- Mid start-bit sample: `8*TICK_DIV` clocks after entering START.
- Each data bit: `16*TICK_DIV` clocks apart.
- Stop decision: `16*TICK_DIV` clocks after the last data sample.
- Strobes (`WEo`, `FRAME_ERRo`, `OVERRUNo`) are registered: high the cycle after the decision tick, for exactly one cycle.
- End-to-end: `WEo` rises `(8 + 16*(DATA_WIDTH+1))*TICK_DIV + 4` ±1 clocks after the `RXi` falling edge.
- Tolerance: ±3% baud mismatch is tolerated at defaults (mid-bit sampling, 1/16-bit resolution).

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t`
  - `localparam int OVERSAMPLE = 16`
  - The package is shared with the future transmitter.
- Sub-module `uart_baud_tick`: parameters `TICK_DIV`; ports `CLKip`, `RSTi`, `CLRi` (sync clear), `TICKo`. It is instantiated once here and is reused by the TX.
- The receiver FSM, synchroniser and shift register live in `uart_rx`.

## Test plan
All scenarios use `CLK_FREQ = 1_600_000`, `BAUD_RATE = 10_000`, giving `TICK_DIV = 10` and 160 clocks/bit.
- **Reset:** hold `RXi = 1` and `RSTi` for 5 cycles → all outputs 0, `BUSYo = 0`.
- **Single frame:** send 0xA5, `FULLi = 0` → one `WEo` pulse with `DATAo = 0xA5`, 1524 ±1 clocks after the start edge; `BUSYo` low afterwards.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap → three `WEo` pulses, data in that order, no error pulses.
- **False start:** 40-clock low glitch on `RXi` → `BUSYo` pulses high, returns to IDLE, no `WEo` or error pulse. A following 0x55 frame is received correctly.
- **Framing/break:** send 0x81 with stop bit low, then hold `RXi` low for 2000 clocks → exactly one `FRAME_ERRo`, no `WEo`. After `RXi` returns high, 0x12 is received.
- **Overrun and mid-frame reset:**
  - Send 0x77 with `FULLi = 1` → one `OVERRUNo`, no `WEo`, `DATAo` unchanged.
  - Assert `RSTi` mid-way through 0x99 → no strobe, `DATAo = 0`, next 0x42 frame received.
- **FIFO integration:** co-simulate with `fifo` (depth 16), receive 17 bytes with no reads → 16 writes and one `OVERRUNo`.
